// File: rtl/fpu_ctrl_pkg.sv
// Shared types, constants and op classification for the FPU sequencing controller.
package fpu_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} fpu_state_e;
    typedef enum logic [1:0] {CLS_NONE, CLS_FIXED, CLS_ITER} fpu_cls_e;

    // Rounding-mode encodings; DYN selects the frm CSR.
    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;
    localparam logic [2:0] DYN = 3'b111;

    localparam logic [31:0] CANON_NAN = 32'h7FC00000;

    // FP ALU function codes, kept in step with the ALU_F* defines in sys_defs.vh.
    localparam logic [4:0] ALU_FCVTSW  = 5'h10;
    localparam logic [4:0] ALU_FCVTSWU = 5'h11;
    localparam logic [4:0] ALU_FCVTWS  = 5'h12;
    localparam logic [4:0] ALU_FCVTWUS = 5'h13;
    localparam logic [4:0] ALU_FSGNJ   = 5'h14;
    localparam logic [4:0] ALU_FSGNJN  = 5'h15;
    localparam logic [4:0] ALU_FSGNJX  = 5'h16;
    localparam logic [4:0] ALU_FEQ     = 5'h17;
    localparam logic [4:0] ALU_FLT     = 5'h18;
    localparam logic [4:0] ALU_FLE     = 5'h19;
    localparam logic [4:0] ALU_FDIV    = 5'h1A;
    localparam logic [4:0] ALU_FSQRT   = 5'h1B;

    // Conversions, sign-injects and compares finish in a fixed number of
    // cycles; divide and square root use the unit's done handshake.
    function automatic fpu_cls_e fpu_op_class(input logic [4:0] func);
        fpu_cls_e cls;
        case (func)
            ALU_FCVTSW, ALU_FCVTSWU, ALU_FCVTWS, ALU_FCVTWUS,
            ALU_FSGNJ, ALU_FSGNJN, ALU_FSGNJX,
            ALU_FEQ, ALU_FLT, ALU_FLE:  cls = CLS_FIXED;
            ALU_FDIV, ALU_FSQRT:        cls = CLS_ITER;
            default:                    cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/fpu_rm_resolve.sv
// Rounding-mode resolution: dynamic mode pulls from frm; reserved encodings flagged.
module fpu_rm_resolve
    import fpu_ctrl_pkg::*;
(
    input  logic [2:0] i_instr_rm,
    input  logic [2:0] i_csr_frm,
    output logic [2:0] o_rm,
    output logic       o_illegal
);

    logic [2:0] w_rm;

    // Pick the effective mode, then flag 101/110/111 as unusable.
    always_comb begin
        w_rm      = (i_instr_rm == DYN) ? i_csr_frm : i_instr_rm;
        o_rm      = w_rm;
        o_illegal = (w_rm == 3'b101) || (w_rm == 3'b110) || (w_rm == 3'b111);
    end

endmodule

// File: rtl/fpu_ctrl.sv
// Sequences one FP op at a time from ID/EX through the FPU and presents its result.
module fpu_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int LAT_CVT      = 1,
    parameter int ITER_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  ID_EX_alu_func,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic [2:0]  instr_rm,
    input  logic [2:0]  csr_frm,
    input  logic        flush,
    output logic [31:0] unit_opa,
    output logic [31:0] unit_opb,
    output logic [4:0]  unit_func,
    output logic [2:0]  unit_rm,
    output logic        unit_start,
    output logic        unit_kill,
    input  logic        unit_done,
    input  logic [31:0] unit_res,
    output logic        busy,
    output logic        res_valid,
    output logic [31:0] res,
    output logic        rm_illegal,
    output logic        timeout
);

    localparam logic [7:0] LAT_LAST = 8'(LAT_CVT - 1);
    localparam logic [7:0] TO_LAST  = 8'(ITER_TIMEOUT - 1);

    fpu_state_e  r_state, w_state_nxt;
    fpu_cls_e    r_cls, w_cls;
    logic [7:0]  r_cnt;
    logic [31:0] r_opa, r_opb, r_res;
    logic [4:0]  r_func;
    logic [2:0]  r_rm, w_rm_res;
    logic        r_rm_illegal, r_timeout;
    logic        w_rm_bad;
    logic        w_accept, w_capture, w_expire;
    logic        w_busy, w_start, w_kill, w_res_valid;

    assign w_cls = fpu_op_class(ID_EX_alu_func);

    fpu_rm_resolve u_rm (
        .i_instr_rm (instr_rm),
        .i_csr_frm  (csr_frm),
        .o_rm       (w_rm_res),
        .o_illegal  (w_rm_bad)
    );

    // Next state and per-cycle controls; flush outranks done and timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_expire    = 1'b0;
        w_busy      = 1'b0;
        w_start     = 1'b0;
        w_kill      = 1'b0;
        w_res_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = issue_valid && (w_cls != CLS_NONE);
                if (w_busy && !flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_rm_bad ? DONE : EXEC;
                end
            end
            EXEC: begin
                w_busy  = 1'b1;
                w_start = (r_cnt == 8'd0);
                if (flush) begin
                    w_kill      = (r_cls == CLS_ITER);
                    w_state_nxt = IDLE;
                end else if (r_cls == CLS_ITER) begin
                    if (unit_done) begin
                        w_capture   = 1'b1;
                        w_state_nxt = DONE;
                    end else if (r_cnt == TO_LAST) begin
                        w_expire    = 1'b1;
                        w_kill      = 1'b1;
                        w_state_nxt = DONE;
                    end
                end else if (r_cnt == LAT_LAST) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_res_valid = !flush;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Operand/function latches, EXEC counter and result/status capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opa        <= '0;
            r_opb        <= '0;
            r_func       <= '0;
            r_rm         <= '0;
            r_cls        <= CLS_NONE;
            r_cnt        <= '0;
            r_res        <= '0;
            r_rm_illegal <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_opa        <= opa;
                r_opb        <= opb;
                r_func       <= ID_EX_alu_func;
                r_rm         <= w_rm_res;
                r_cls        <= w_cls;
                r_cnt        <= '0;
                r_res        <= '0;
                r_rm_illegal <= w_rm_bad;
                r_timeout    <= 1'b0;
            end else if (r_state == EXEC) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_capture) r_res <= unit_res;
            if (w_expire) begin
                r_res     <= CANON_NAN;
                r_timeout <= 1'b1;
            end
        end
    end

    assign unit_opa   = r_opa;
    assign unit_opb   = r_opb;
    assign unit_func  = r_func;
    assign unit_rm    = r_rm;
    assign unit_start = w_start;
    assign unit_kill  = w_kill;
    assign busy       = w_busy;
    assign res_valid  = w_res_valid;
    assign res        = r_res;
    assign rm_illegal = r_rm_illegal;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_fpu_ctrl.sv
// Bench for fpu_ctrl: directed literal checks plus randomized traffic against a timeline model.
module tb_fpu_ctrl;
    import fpu_ctrl_pkg::*;

    localparam int LAT = 2;
    localparam int ITO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  func = '0;
    logic [31:0] opa = '0, opb = '0;
    logic [2:0]  instr_rm = '0, csr_frm = '0;
    logic        flush = 1'b0;
    logic        unit_done = 1'b0;
    logic [31:0] unit_res = '0;
    logic [31:0] unit_opa, unit_opb, res;
    logic [4:0]  unit_func;
    logic [2:0]  unit_rm;
    logic        unit_start, unit_kill, busy, res_valid, rm_illegal, timeout;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    fpu_ctrl #(.LAT_CVT(LAT), .ITER_TIMEOUT(ITO)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .ID_EX_alu_func(func),
        .opa(opa), .opb(opb), .instr_rm(instr_rm), .csr_frm(csr_frm), .flush(flush),
        .unit_opa(unit_opa), .unit_opb(unit_opb), .unit_func(unit_func), .unit_rm(unit_rm),
        .unit_start(unit_start), .unit_kill(unit_kill), .unit_done(unit_done),
        .unit_res(unit_res), .busy(busy), .res_valid(res_valid), .res(res),
        .rm_illegal(rm_illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Class table kept independently of the package helper.
    function automatic int bclass(input logic [4:0] f);
        if (f == ALU_FDIV || f == ALU_FSQRT) return 2;
        if (f >= 5'h10 && f <= 5'h19) return 1;
        return 0;
    endfunction

    // Timeline model: m_k counts EXEC cycles since accept (1 = start cycle).
    bit          m_inop = 0, m_show = 0, m_iter = 0, m_ill = 0, m_to = 0;
    int          m_k = 0;
    logic [31:0] m_opa = '0, m_opb = '0, m_res = '0;
    logic [4:0]  m_func = '0;
    logic [2:0]  m_rm = '0;

    always @(negedge clk) begin
        logic [2:0] rr;
        if (chk_en) begin
            chk("busy", busy, m_inop ? 1 : (m_show ? 0 : ((issue_valid && bclass(func) != 0) ? 1 : 0)));
            chk("unit_start", unit_start, (m_inop && m_k == 1) ? 1 : 0);
            chk("unit_kill", unit_kill, (m_inop && m_iter && (flush || (!unit_done && m_k == ITO))) ? 1 : 0);
            chk("res_valid", res_valid, (m_show && !flush) ? 1 : 0);
            chk("res", res, m_res);
            chk("rm_illegal", rm_illegal, m_ill);
            chk("timeout", timeout, m_to);
            chk("unit_opa", unit_opa, m_opa);
            chk("unit_opb", unit_opb, m_opb);
            chk("unit_func", unit_func, m_func);
            chk("unit_rm", unit_rm, m_rm);
        end
        if (rst) begin
            m_inop = 0; m_show = 0; m_iter = 0; m_ill = 0; m_to = 0; m_k = 0;
            m_opa = '0; m_opb = '0; m_res = '0; m_func = '0; m_rm = '0;
        end else if (m_show) begin
            m_show = 0;
        end else if (m_inop) begin
            if (flush) m_inop = 0;
            else if (m_iter && unit_done) begin m_res = unit_res; m_inop = 0; m_show = 1; end
            else if (m_iter && m_k == ITO) begin m_res = 32'h7FC00000; m_to = 1; m_inop = 0; m_show = 1; end
            else if (!m_iter && m_k == LAT) begin m_res = unit_res; m_inop = 0; m_show = 1; end
            else m_k++;
        end else if (issue_valid && bclass(func) != 0 && !flush) begin
            rr = (instr_rm == 3'd7) ? csr_frm : instr_rm;
            m_opa = opa; m_opb = opb; m_func = func; m_rm = rr;
            m_iter = (bclass(func) == 2);
            m_ill = (rr >= 3'd5);
            m_res = '0; m_to = 0; m_k = 1;
            if (m_ill) m_show = 1; else m_inop = 1;
        end
    end

    task automatic wait_rv(input string nm, input int budget);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            if (res_valid === 1'b1) got = 1;
            else begin cyc(); #1; end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s res_valid not seen within %0d cycles", nm, budget);
        end
    endtask

    task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [2:0] irm, input logic [2:0] frm);
        issue_valid = 1'b1; func = f; opa = a; opb = 32'h0000_1234;
        instr_rm = irm; csr_frm = frm;
    endtask

    initial begin
        int nrv;
        cyc();
        chk_en = 1'b1;
        cyc();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_res", res, 0);
        cyc();
        rst = 1'b0;

        // FCVTSW, LAT=2: start at T+1, result at T+3
        cyc(); issue(ALU_FCVTSW, 32'hFFFFFFFE, RNE, RUP); unit_res = 32'hC0000000; #1;
        chk("t1_busy_T", busy, 1);
        cyc(); issue_valid = 1'b0; #1;
        chk("t1_start_T1", unit_start, 1);
        chk("t1_rm", unit_rm, 0);
        chk("t1_opa", unit_opa, 32'hFFFFFFFE);
        cyc(); #1;
        chk("t1_start_T2", unit_start, 0);
        chk("t1_busy_T2", busy, 1);
        cyc(); #1;
        chk("t1_rv_T3", res_valid, 1);
        chk("t1_res", res, 32'hC0000000);
        chk("t1_busy_T3", busy, 0);
        cyc(); #1;
        chk("t1_rv_once", res_valid, 0);
        chk("t1_res_hold", res, 32'hC0000000);

        // Dynamic rm from frm, then an illegal dynamic rm
        cyc(); issue(ALU_FEQ, 32'h1, DYN, RUP); #1;
        cyc(); issue_valid = 1'b0; #1;
        chk("t2_dyn_rm", unit_rm, 3'b011);
        wait_rv("t2_dyn_done", 6);
        cyc(); issue(ALU_FCVTSW, 32'h2, DYN, 3'b101); #1;
        chk("t2_ill_busy", busy, 1);
        cyc(); issue_valid = 1'b0; #1;
        chk("t2_ill_rv", res_valid, 1);
        chk("t2_ill_flag", rm_illegal, 1);
        chk("t2_ill_start", unit_start, 0);
        chk("t2_ill_res", res, 0);

        // FDIV with done 5 cycles after start
        cyc(); issue(ALU_FDIV, 32'h40400000, RNE, RNE); unit_done = 1'b0; #1;
        cyc(); issue_valid = 1'b0; #1;
        chk("t3_start", unit_start, 1);
        repeat (4) cyc();
        #1;
        chk("t3_rv_early", res_valid, 0);
        cyc(); unit_done = 1'b1; unit_res = 32'h3F800000; #1;
        chk("t3_busy_done", busy, 1);
        cyc(); unit_done = 1'b0; #1;
        chk("t3_rv", res_valid, 1);
        chk("t3_res", res, 32'h3F800000);
        chk("t3_busy_drop", busy, 0);

        // FSQRT with no done: kill on the 8th EXEC cycle
        cyc(); issue(ALU_FSQRT, 32'h41000000, RTZ, RNE); #1;
        cyc(); issue_valid = 1'b0; #1;
        for (int i = 1; i < ITO; i++) begin
            chk("t4_no_kill", unit_kill, 0);
            cyc(); #1;
        end
        chk("t4_kill", unit_kill, 1);
        cyc(); #1;
        chk("t4_rv", res_valid, 1);
        chk("t4_nan", res, 32'h7FC00000);
        chk("t4_to", timeout, 1);

        // Flush in the 2nd EXEC cycle of FDIV, racing unit_done
        cyc(); issue(ALU_FDIV, 32'h5, RNE, RNE); #1;
        cyc(); issue_valid = 1'b0; #1;
        cyc(); flush = 1'b1; unit_done = 1'b1; #1;
        chk("t5_kill", unit_kill, 1);
        cyc(); flush = 1'b0; unit_done = 1'b0; #1;
        chk("t5_idle_busy", busy, 0);
        chk("t5_no_rv", res_valid, 0);
        cyc(); issue(ALU_FCVTWS, 32'h6, RDN, RNE); unit_res = 32'h00000042; #1;
        cyc(); issue_valid = 1'b0; #1;
        wait_rv("t5_next_op", 6);
        chk("t5_next_res", res, 32'h00000042);

        // Reset mid-EXEC, then back-to-back FCVTSWU
        cyc(); issue(ALU_FDIV, 32'h7, RNE, RNE); #1;
        cyc(); issue_valid = 1'b0; #1;
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0; #1;
        chk("t6_busy0", busy, 0);
        chk("t6_opa0", unit_opa, 0);
        chk("t6_res0", res, 0);
        chk("t6_kill0", unit_kill, 0);
        nrv = 0;
        cyc(); issue(ALU_FCVTSWU, 32'h9, RMM, RNE); unit_res = 32'h41100000; #1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin chk("t6_done_busy", busy, 0); chk("t6_done_rv", res_valid, 1); end
            if (i == 4) chk("t6_reaccept", busy, 1);
            if (i == 5) chk("t6_start2", unit_start, 1);
            if (res_valid === 1'b1) nrv++;
            cyc();
            if (i == 4) issue_valid = 1'b0;
            #1;
        end
        chk("t6_rv_count", nrv, 2);

        // Randomized traffic, checked every cycle by the model
        for (int n = 0; n < 4000; n++) begin
            cyc();
            rst         = ($urandom_range(0, 299) == 0);
            issue_valid = ($urandom_range(0, 2) != 0);
            func        = ($urandom_range(0, 3) == 0) ? ALU_FDIV : 5'($urandom_range(0, 31));
            opa         = $urandom;
            opb         = $urandom;
            instr_rm    = 3'($urandom_range(0, 7));
            csr_frm     = 3'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 19) == 0);
            unit_done   = ($urandom_range(0, 6) == 0);
            unit_res    = $urandom;
        end
        cyc();
        rst = 1'b0; issue_valid = 1'b0; flush = 1'b0; unit_done = 1'b0;
        repeat (20) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
